adder_share_arbiter: RTL

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

---
 rtl/adder_share_arbiter_pkg.sv | 13 +
 rtl/Carry_look_ahead_adder.sv | 40 ++++
 rtl/adder_share_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
// Holds the FSM state encoding and the completion counter width.
package adder_share_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int OP_COUNT_W = 16;
  localparam int CLA_W      = 32;

endpackage

// File: rtl/Carry_look_ahead_adder.sv
// 32-bit adder built from eight 4-bit carry-lookahead groups chained by group carry.
// Carry-in is tied low; C is the carry-out of bit 31.
module Carry_look_ahead_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        C
);

  logic [31:0] w_p;
  logic [31:0] w_g;
  logic [8:0]  w_gc;

  assign w_p     = A ^ B;
  assign w_g     = A & B;
  assign w_gc[0] = 1'b0;

  for (genvar k = 0; k < 8; k++) begin : g_grp
    logic [3:0] w_gp;
    logic [3:0] w_gg;
    logic [4:0] w_c;

    assign w_gp   = w_p[4*k +: 4];
    assign w_gg   = w_g[4*k +: 4];
    assign w_c[0] = w_gc[k];
    assign w_c[1] = w_gg[0] | (w_gp[0] & w_c[0]);
    assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_c[0]);
    assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & w_c[0]);
    assign w_c[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_c[0]);

    assign S[4*k +: 4] = w_gp ^ w_c[3:0];
    assign w_gc[k+1]   = w_c[4];
  end

  assign C = w_gc[8];

endmodule

// File: rtl/adder_share_arbiter.sv
// Two requesters share one carry-lookahead adder through a round-robin arbiter;
// an accepted pair is held as a result until the consumer takes it.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WIDTH-1:0]      req0_a,
  input  logic [WIDTH-1:0]      req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WIDTH-1:0]      req1_a,
  input  logic [WIDTH-1:0]      req1_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_carry,
  output logic                  res_ovf,
  output logic                  res_id,
  output logic [OP_COUNT_W-1:0] op_count
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic                  r_id;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic [OP_COUNT_W-1:0] r_op_count;

  logic                  w_grant;
  logic                  w_accept;
  logic                  w_hold;
  logic                  w_done;
  logic [CLA_W-1:0]      w_a_ext;
  logic [CLA_W-1:0]      w_b_ext;
  logic [CLA_W-1:0]      w_cla_s;
  logic                  w_cla_c;
  logic [CLA_W:0]        w_full;
  logic [WIDTH-1:0]      w_sum;
  logic                  w_carry;
  logic                  w_ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_grant      = r_last_grant;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid && req1_valid) w_grant = ~r_last_grant;
        else if (req0_valid)          w_grant = 1'b0;
        else if (req1_valid)          w_grant = 1'b1;
        req0_ready = req0_valid && !w_grant;
        req1_ready = req1_valid &&  w_grant;
        if (req0_ready || req1_ready) w_next_state = HOLD;
      end
      HOLD: begin
        if (res_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_accept = req0_ready | req1_ready;
  assign w_hold   = (r_state == HOLD);
  assign w_done   = w_hold & res_ready;

  // NOTE: only a few control/operand registers exist here, so all of them are
  // reset; last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_op_count   <= '0;
    end else begin
      if (w_accept) begin
        r_a          <= w_grant ? req1_a : req0_a;
        r_b          <= w_grant ? req1_b : req0_b;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
      end
      if (w_done) r_op_count <= r_op_count + OP_COUNT_W'(1);
    end
  end

  // Operands narrower than the fixed 32-bit adder are zero-extended; the
  // carry for such widths is then the adder's sum bit just above the MSB.
  always_comb begin
    w_a_ext             = '0;
    w_b_ext             = '0;
    w_a_ext[WIDTH-1:0]  = r_a;
    w_b_ext[WIDTH-1:0]  = r_b;
  end

  Carry_look_ahead_adder u_cla (
    .A (w_a_ext),
    .B (w_b_ext),
    .S (w_cla_s),
    .C (w_cla_c)
  );

  assign w_full  = {w_cla_c, w_cla_s};
  assign w_sum   = w_full[WIDTH-1:0];
  assign w_carry = w_full[WIDTH];
  assign w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

  assign res_valid = w_hold;
  assign res_sum   = w_hold ? w_sum : '0;
  assign res_carry = w_hold & w_carry;
  assign res_ovf   = w_hold & w_ovf;
  assign res_id    = w_hold & r_id;
  assign op_count  = r_op_count;

endmodule
